// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between board-level switches, the PLL pins
// and the lock sequencer.
interface pll_lock_sequencer_if #(
  parameter int RETRY_W = 2
) ();
  logic               en_i;
  logic               pwrdwn_i;
  logic               clr_i;
  logic               pll_locked_i;
  logic               pll_rst_o;
  logic               pll_pwrdwn_o;
  logic               cnt_rst_o;
  logic               ready_o;
  logic               fault_o;
  logic               lock_lost_o;
  logic [RETRY_W-1:0] retry_cnt_o;
  logic [2:0]         state_o;

  modport master (
    output en_i, pwrdwn_i, clr_i, pll_locked_i,
    input  pll_rst_o, pll_pwrdwn_o, cnt_rst_o, ready_o,
    input  fault_o, lock_lost_o, retry_cnt_o, state_o
  );

  modport slave (
    input  en_i, pwrdwn_i, clr_i, pll_locked_i,
    output pll_rst_o, pll_pwrdwn_o, cnt_rst_o, ready_o,
    output fault_o, lock_lost_o, retry_cnt_o, state_o
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/power-down sequencing with lock qualification and retry.
// All outputs are registered and decoded from the next state.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int RETRY_W       = $clog2(MAX_RETRIES + 1)
) (
  input logic                 clk,
  input logic                 rst,
  pll_lock_sequencer_if.slave bus
);
  localparam int TMAX =
    (LOCK_TIMEOUT > RST_CYCLES) ?
    ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES) :
    ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES);
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_RST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STAB = TW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] R_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_HOLD  = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5,
    PWRDN     = 3'd6
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [1:0]         sync;
  logic               lk;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      timer_nxt;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lost_set;
  logic               pll_rst;
  logic               pll_pwrdwn;
  logic               cnt_rst;
  logic               ready;
  logic               fault;
  logic               lock_lost;

  assign lk = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], bus.pll_locked_i};
  end

  always_comb begin
    nxt       = state;
    retry_nxt = retry;
    if (bus.pwrdwn_i) begin
      nxt = PWRDN;
    end else if (!bus.en_i) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:     nxt = RST_HOLD;
        RST_HOLD: if (timer == T_RST) nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lk) begin
            nxt = STABLE;
          end else if (timer == T_LOCK) begin
            if (retry == R_MAX) begin
              nxt = FAULT;
            end else begin
              nxt       = RST_HOLD;
              retry_nxt = retry + RETRY_W'(1);
            end
          end
        end
        STABLE: begin
          if (!lk)                  nxt = WAIT_LOCK;
          else if (timer == T_STAB) nxt = RUN;
        end
        RUN:      if (!lk) nxt = RST_HOLD;
        FAULT:    nxt = FAULT;
        PWRDN:    nxt = IDLE;
        default:  nxt = IDLE;
      endcase
    end
    if (nxt inside {IDLE, PWRDN, RUN}) retry_nxt = '0;
  end

  // Timer restarts on every state change and only runs in timed states.
  always_comb begin
    timer_nxt = '0;
    if (nxt == state && nxt inside {RST_HOLD, WAIT_LOCK, STABLE})
      timer_nxt = (timer == '1) ? timer : timer + TW'(1);
  end

  assign lost_set = (state == RUN) && !lk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      retry      <= '0;
      pll_rst    <= 1'b1;
      pll_pwrdwn <= 1'b0;
      cnt_rst    <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= nxt;
      timer      <= timer_nxt;
      retry      <= retry_nxt;
      pll_rst    <= nxt inside {IDLE, RST_HOLD, FAULT, PWRDN};
      pll_pwrdwn <= (nxt == PWRDN);
      cnt_rst    <= (nxt != RUN);
      ready      <= (nxt == RUN);
      fault      <= (nxt == FAULT);
      lock_lost  <= lost_set | (lock_lost & ~bus.clr_i);
    end
  end

  assign bus.pll_rst_o    = pll_rst;
  assign bus.pll_pwrdwn_o = pll_pwrdwn;
  assign bus.cnt_rst_o    = cnt_rst;
  assign bus.ready_o      = ready;
  assign bus.fault_o      = fault;
  assign bus.lock_lost_o  = lock_lost;
  assign bus.retry_cnt_o  = retry;
  assign bus.state_o      = state;
endmodule
